// File: rtl/count_checker.sv
// Observer for a free-running up-counter: one-shot target detection, hold-window
// check after the first hit, per-sample step legality and a saturating error tally.
module count_checker #(
  parameter int WIDTH       = 4,
  parameter int TARGET      = 10,
  parameter int HOLD_CYCLES = 1,
  parameter int STEP        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic             clear,
  output logic             hit,
  output logic             triggered,
  output logic             stable_ok,
  output logic             stable_err,
  output logic             step_err,
  output logic [7:0]       err_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] TARGET_V = TARGET[WIDTH-1:0];
  localparam logic [WIDTH-1:0] STEP_V   = STEP[WIDTH-1:0];
  localparam logic [3:0]       HOLD_V   = HOLD_CYCLES[3:0];

  state_t           cur;
  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  logic [3:0]       hold_cnt;

  logic [WIDTH-1:0] delta;
  logic             is_target;
  logic             step_bad;
  logic             hold_bad;

  // The step check is skipped in HOLD so a bad hold sample is only counted once.
  assign delta     = count - prev;
  assign is_target = (count == TARGET_V);
  assign step_bad  = prev_valid && (cur != HOLD) && (delta != '0) && (delta != STEP_V);
  assign hold_bad  = (cur == HOLD) && !is_target;
  assign state     = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= ARM;
      prev       <= '0;
      prev_valid <= 1'b0;
      hold_cnt   <= '0;
      hit        <= 1'b0;
      triggered  <= 1'b0;
      stable_ok  <= 1'b0;
      stable_err <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
    end else if (clear) begin
      cur        <= ARM;
      prev_valid <= 1'b0;
      hold_cnt   <= '0;
      hit        <= 1'b0;
      triggered  <= 1'b0;
      stable_ok  <= 1'b0;
      stable_err <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      hit        <= 1'b0;
      stable_ok  <= 1'b0;
      stable_err <= 1'b0;
      step_err   <= 1'b0;
      if (enable) begin
        prev       <= count;
        prev_valid <= 1'b1;
        step_err   <= step_bad;
        if ((step_bad || hold_bad) && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
        unique case (cur)
          ARM, TRACK: begin
            if (is_target) begin
              hit       <= 1'b1;
              triggered <= 1'b1;
              hold_cnt  <= HOLD_V;
              cur       <= HOLD;
            end else begin
              cur <= TRACK;
            end
          end
          HOLD: begin
            if (!is_target) begin
              stable_err <= 1'b1;
              cur        <= DONE;
            end else begin
              hold_cnt <= hold_cnt - 4'd1;
              // Window completes on the sample that takes the counter to zero.
              if (hold_cnt == 4'd1) begin
                stable_ok <= 1'b1;
                cur       <= DONE;
              end
            end
          end
          DONE: cur <= DONE;
          default: cur <= ARM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: a behavioural reference model feeds a
// scoreboard queue, plus directed end-of-scenario checks against fixed values.
module tb_count_checker;

  logic       clk = 1'b0;
  logic       reset, enable, clear;
  logic [3:0] count;
  logic       hit, triggered, stable_ok, stable_err, step_err;
  logic [7:0] err_count;
  logic [1:0] state;

  count_checker #(.WIDTH(4), .TARGET(10), .HOLD_CYCLES(1), .STEP(1)) dut (
    .clk(clk), .reset(reset), .count(count), .enable(enable), .clear(clear),
    .hit(hit), .triggered(triggered), .stable_ok(stable_ok),
    .stable_err(stable_err), .step_err(step_err), .err_count(err_count),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic       trig;
    logic       ok;
    logic       serr;
    logic       steperr;
    logic [7:0] err;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   hits = 0;
  int   steperrs = 0;

  // Reference model state
  logic [1:0] m_state;
  logic [3:0] m_prev;
  logic       m_pv;
  logic       m_trig;
  int         m_hold;
  int         m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e, o;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    o = '{hit, triggered, stable_ok, stable_err, step_err, err_count, state};
    if (hit === 1'b1) hits++;
    if (step_err === 1'b1) steperrs++;
    check(tag, 32'(o), 32'(e));
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] c,
                               input logic en, input logic clr, input logic rst);
    exp_t e;
    logic [3:0] d;
    @(negedge clk);
    count = c; enable = en; clear = clr; reset = rst;
    e = '0;
    if (rst) begin
      m_state = 2'd0; m_prev = '0; m_pv = 1'b0; m_trig = 1'b0; m_hold = 0; m_err = 0;
    end else if (clr) begin
      m_state = 2'd0; m_pv = 1'b0; m_trig = 1'b0; m_hold = 0;
    end else if (en) begin
      if (m_state != 2'd2 && m_pv) begin
        d = c - m_prev;
        if (d != 4'd0 && d != 4'd1) e.steperr = 1'b1;
      end
      case (m_state)
        2'd0, 2'd1: begin
          if (c == 4'd10) begin
            e.hit = 1'b1; m_trig = 1'b1; m_hold = 1; m_state = 2'd2;
          end else m_state = 2'd1;
        end
        2'd2: begin
          if (c != 4'd10) begin
            e.serr = 1'b1; m_state = 2'd3;
          end else begin
            m_hold = m_hold - 1;
            if (m_hold == 0) begin e.ok = 1'b1; m_state = 2'd3; end
          end
        end
        default: m_state = 2'd3;
      endcase
      if ((e.serr || e.steperr) && m_err < 255) m_err = m_err + 1;
      m_prev = c; m_pv = 1'b1;
    end
    e.trig = m_trig; e.err = m_err[7:0]; e.st = m_state;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; count = '0;

    // Scenario 1: straight count to 10, hold completes
    applyStimulus("s1_reset", 4'd0, 1'b0, 1'b0, 1'b1);
    check("s1_reset_outputs", 32'({hit, triggered, stable_ok, stable_err, step_err, err_count, state}), 32'd0);
    hits = 0;
    for (int i = 0; i <= 10; i++) applyStimulus("s1_count", 4'(i), 1'b1, 1'b0, 1'b0);
    check("s1_hit_once", 32'(hits), 32'd1);
    applyStimulus("s1_hold", 4'd10, 1'b1, 1'b0, 1'b0);
    check("s1_stable_ok", 32'(stable_ok), 32'd1);
    applyStimulus("s1_after", 4'd11, 1'b1, 1'b0, 1'b0);
    check("s1_state_done", 32'(state), 32'd3);
    check("s1_triggered", 32'(triggered), 32'd1);
    check("s1_err_zero", 32'(err_count), 32'd0);

    // Scenario 2: hold window broken by 11
    applyStimulus("s2_reset", 4'd0, 1'b0, 1'b0, 1'b1);
    steperrs = 0;
    applyStimulus("s2_8", 4'd8, 1'b1, 1'b0, 1'b0);
    applyStimulus("s2_9", 4'd9, 1'b1, 1'b0, 1'b0);
    applyStimulus("s2_10", 4'd10, 1'b1, 1'b0, 1'b0);
    applyStimulus("s2_11", 4'd11, 1'b1, 1'b0, 1'b0);
    check("s2_stable_err", 32'(stable_err), 32'd1);
    check("s2_err_one", 32'(err_count), 32'd1);
    check("s2_no_step_err", 32'(steperrs), 32'd0);

    // Scenario 3: illegal jump, then legal wrap
    applyStimulus("s3_reset", 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("s3_3", 4'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus("s3_4", 4'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus("s3_7", 4'd7, 1'b1, 1'b0, 1'b0);
    check("s3_step_err", 32'(step_err), 32'd1);
    check("s3_err_one", 32'(err_count), 32'd1);
    applyStimulus("s3_reset2", 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("s3_14", 4'd14, 1'b1, 1'b0, 1'b0);
    applyStimulus("s3_15", 4'd15, 1'b1, 1'b0, 1'b0);
    applyStimulus("s3_0", 4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("s3_1", 4'd1, 1'b1, 1'b0, 1'b0);
    check("s3_wrap_no_err", 32'(err_count), 32'd0);

    // Scenario 4: first-match only, then clear re-arms and keeps err_count
    applyStimulus("s4_reset", 4'd0, 1'b0, 1'b0, 1'b1);
    hits = 0;
    for (int i = 0; i <= 10; i++) applyStimulus("s4_up", 4'(i), 1'b1, 1'b0, 1'b0);
    applyStimulus("s4_hold", 4'd10, 1'b1, 1'b0, 1'b0);
    applyStimulus("s4_jump", 4'd13, 1'b1, 1'b0, 1'b0);
    for (int i = 14; i <= 26; i++) applyStimulus("s4_wrap", 4'(i % 16), 1'b1, 1'b0, 1'b0);
    check("s4_single_hit", 32'(hits), 32'd1);
    check("s4_err_before_clear", 32'(err_count), 32'd1);
    applyStimulus("s4_clear", 4'd10, 1'b1, 1'b1, 1'b0);
    check("s4_trig_dropped", 32'(triggered), 32'd0);
    check("s4_err_kept", 32'(err_count), 32'd1);
    applyStimulus("s4_9", 4'd9, 1'b1, 1'b0, 1'b0);
    applyStimulus("s4_10", 4'd10, 1'b1, 1'b0, 1'b0);
    check("s4_rehit", 32'(hit), 32'd1);
    applyStimulus("s4_10b", 4'd10, 1'b1, 1'b0, 1'b0);
    check("s4_hits_total", 32'(hits), 32'd2);

    // Scenario 5: reset in the middle of the hold window
    applyStimulus("s5_reset", 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("s5_9", 4'd9, 1'b1, 1'b0, 1'b0);
    applyStimulus("s5_10", 4'd10, 1'b1, 1'b0, 1'b0);
    check("s5_in_hold", 32'(state), 32'd2);
    applyStimulus("s5_reset_hold", 4'd5, 1'b1, 1'b0, 1'b1);
    check("s5_all_zero", 32'({hit, triggered, stable_ok, stable_err, step_err, err_count, state}), 32'd0);

    // Scenario 6: saturation, then enable gating freezes the baseline
    applyStimulus("s6_reset", 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) applyStimulus("s6_sat", 4'((i % 2) * 2), 1'b1, 1'b0, 1'b0);
    check("s6_err_sat", 32'(err_count), 32'd255);
    steperrs = 0;
    applyStimulus("s6_off_9", 4'd9, 1'b0, 1'b0, 1'b0);
    applyStimulus("s6_off_5", 4'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus("s6_off_13", 4'd13, 1'b0, 1'b0, 1'b0);
    applyStimulus("s6_on_2", 4'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus("s6_on_3", 4'd3, 1'b1, 1'b0, 1'b0);
    check("s6_prev_held", 32'(steperrs), 32'd0);
    check("s6_err_still_sat", 32'(err_count), 32'd255);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
